id_ex_stage: RTL and testbench

- ID/EX pipeline stage of the rv32 core, directly upstream of the ALU.
- Registers decoded instruction fields and applies EX-stage operand forwarding from EX/MEM and MEM/WB.
- Selects the ALU operands and drives the ALU's operand, select and sign inputs.
- Detects load-use hazards, stalls decode and inserts a bubble.

---
 rtl/rv32_pkg.sv | 23 ++
 rtl/fwd_mux.sv | 36 +++
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 tb/tb_id_ex_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared rv32 core definitions: datapath defaults and ALU operation codes.
package rv32_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;

  typedef logic [3:0] alu_sel_t;

  // ALU operation codes; 0x5 and 0xD-0xF are unassigned.
  localparam alu_sel_t ALU_AND   = 4'h0;
  localparam alu_sel_t ALU_OR    = 4'h1;
  localparam alu_sel_t ALU_XOR   = 4'h2;
  localparam alu_sel_t ALU_ADD   = 4'h3;
  localparam alu_sel_t ALU_SUB   = 4'h4;
  localparam alu_sel_t ALU_PASSB = 4'h6;
  localparam alu_sel_t ALU_SLL   = 4'h7;
  localparam alu_sel_t ALU_SRL   = 4'h8;
  localparam alu_sel_t ALU_SRA   = 4'h9;
  localparam alu_sel_t ALU_SLA   = 4'hA;
  localparam alu_sel_t ALU_SLTU  = 4'hB;
  localparam alu_sel_t ALU_SLT   = 4'hC;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding mux: picks the newest in-flight value of one source
// register, EX/MEM first, then MEM/WB, else the register-file read data.
module fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [XLEN-1:0]   reg_data,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [XLEN-1:0]   memwb_result,
  output logic [XLEN-1:0]   fwd_data
);

  logic exmem_hit;
  logic memwb_hit;

  // x0 is hard-wired to zero, so a writer targeting it never forwards.
  assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_addr);
  assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_addr);

  // Priority select: the younger EX/MEM result shadows MEM/WB.
  always_comb begin
    // NOTE: default first so every path assigns fwd_data and no latch is inferred.
    fwd_data = reg_data;
    if (exmem_hit) begin
      fwd_data = exmem_result;
    end else if (memwb_hit) begin
      fwd_data = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the rv32 core: holds decoded fields, forwards
// operands from EX/MEM and MEM/WB, drives the ALU and detects load-use hazards.
module id_ex_stage
  import rv32_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [REG_AW-1:0] i_rs1_addr,
  input  logic [REG_AW-1:0] i_rs2_addr,
  input  logic              i_rs1_used,
  input  logic              i_rs2_used,
  input  logic [XLEN-1:0]   i_rs1_data,
  input  logic [XLEN-1:0]   i_rs2_data,
  input  logic [XLEN-1:0]   i_imm,
  input  logic [REG_AW-1:0] i_rd_addr,
  input  alu_sel_t          i_alu_sel,
  input  logic              i_sign,
  input  logic              i_a_is_pc,
  input  logic              i_b_is_imm,
  input  logic              i_reg_write,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_flush,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic              i_exmem_reg_write,
  input  logic [XLEN-1:0]   i_exmem_result,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic              i_memwb_reg_write,
  input  logic [XLEN-1:0]   i_memwb_result,
  output logic              o_stall,
  output logic              o_valid,
  output logic [XLEN-1:0]   o_pc,
  output logic [XLEN-1:0]   o_alu_a,
  output logic [XLEN-1:0]   o_alu_b,
  output alu_sel_t          o_alu_sel,
  output logic              o_sign,
  output logic [XLEN-1:0]   o_store_data,
  output logic [REG_AW-1:0] o_rd_addr,
  output logic              o_reg_write,
  output logic              o_mem_read,
  output logic              o_mem_write
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd_addr;
    alu_sel_t          alu_sel;
    logic              sign;
    logic              a_is_pc;
    logic              b_is_imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } id_ex_t;

  id_ex_t          ex_q;
  id_ex_t          ex_d;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            rs1_hazard;
  logic            rs2_hazard;

  // Load-use: the load in EX produces its data too late for the consumer in decode.
  assign rs1_hazard = i_rs1_used && (i_rs1_addr == ex_q.rd_addr);
  assign rs2_hazard = i_rs2_used && (i_rs2_addr == ex_q.rd_addr);
  assign o_stall    = i_valid && o_valid && o_mem_read && (ex_q.rd_addr != '0)
                      && (rs1_hazard || rs2_hazard);

  // Next-state select: flush beats stall; both load an all-zero bubble.
  always_comb begin
    ex_d = '0;
    if (!i_flush && !o_stall) begin
      ex_d.valid     = i_valid;
      ex_d.pc        = i_pc;
      ex_d.rs1_addr  = i_rs1_addr;
      ex_d.rs2_addr  = i_rs2_addr;
      ex_d.rs1_data  = i_rs1_data;
      ex_d.rs2_data  = i_rs2_data;
      ex_d.imm       = i_imm;
      ex_d.rd_addr   = i_rd_addr;
      ex_d.alu_sel   = i_alu_sel;
      ex_d.sign      = i_sign;
      ex_d.a_is_pc   = i_a_is_pc;
      ex_d.b_is_imm  = i_b_is_imm;
      ex_d.reg_write = i_reg_write;
      ex_d.mem_read  = i_mem_read;
      ex_d.mem_write = i_mem_write;
    end
  end

  // Pipeline register with asynchronous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (i_rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_addr         (ex_q.rs1_addr),
    .reg_data        (ex_q.rs1_data),
    .exmem_rd        (i_exmem_rd),
    .exmem_reg_write (i_exmem_reg_write),
    .exmem_result    (i_exmem_result),
    .memwb_rd        (i_memwb_rd),
    .memwb_reg_write (i_memwb_reg_write),
    .memwb_result    (i_memwb_result),
    .fwd_data        (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_addr         (ex_q.rs2_addr),
    .reg_data        (ex_q.rs2_data),
    .exmem_rd        (i_exmem_rd),
    .exmem_reg_write (i_exmem_reg_write),
    .exmem_result    (i_exmem_result),
    .memwb_rd        (i_memwb_rd),
    .memwb_reg_write (i_memwb_reg_write),
    .memwb_result    (i_memwb_result),
    .fwd_data        (fwd_rs2)
  );

  assign o_valid      = ex_q.valid;
  assign o_pc         = ex_q.pc;
  assign o_alu_a      = ex_q.a_is_pc  ? ex_q.pc  : fwd_rs1;
  assign o_alu_b      = ex_q.b_is_imm ? ex_q.imm : fwd_rs2;
  assign o_store_data = fwd_rs2;
  assign o_alu_sel    = ex_q.alu_sel;
  assign o_sign       = ex_q.sign;
  assign o_rd_addr    = ex_q.rd_addr;
  assign o_reg_write  = ex_q.valid && ex_q.reg_write;
  assign o_mem_read   = ex_q.valid && ex_q.mem_read;
  assign o_mem_write  = ex_q.valid && ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected EX contents are queued when a
// decode slot is driven and compared one edge later.
module tb_id_ex_stage;
  import rv32_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [31:0] i_pc;
  logic [4:0]  i_rs1_addr, i_rs2_addr;
  logic        i_rs1_used, i_rs2_used;
  logic [31:0] i_rs1_data, i_rs2_data, i_imm;
  logic [4:0]  i_rd_addr;
  logic [3:0]  i_alu_sel;
  logic        i_sign, i_a_is_pc, i_b_is_imm;
  logic        i_reg_write, i_mem_read, i_mem_write, i_flush;
  logic [4:0]  i_exmem_rd;
  logic        i_exmem_reg_write;
  logic [31:0] i_exmem_result;
  logic [4:0]  i_memwb_rd;
  logic        i_memwb_reg_write;
  logic [31:0] i_memwb_result;
  logic        o_stall, o_valid;
  logic [31:0] o_pc, o_alu_a, o_alu_b, o_store_data;
  logic [3:0]  o_alu_sel;
  logic        o_sign;
  logic [4:0]  o_rd_addr;
  logic        o_reg_write, o_mem_read, o_mem_write;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] pc, a, b, sd;
    logic [3:0]  sel;
    logic        sign;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } exp_t;

  exp_t sb[$];

  id_ex_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_pc(i_pc),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
    .i_rd_addr(i_rd_addr), .i_alu_sel(i_alu_sel), .i_sign(i_sign),
    .i_a_is_pc(i_a_is_pc), .i_b_is_imm(i_b_is_imm),
    .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_flush(i_flush),
    .i_exmem_rd(i_exmem_rd), .i_exmem_reg_write(i_exmem_reg_write),
    .i_exmem_result(i_exmem_result),
    .i_memwb_rd(i_memwb_rd), .i_memwb_reg_write(i_memwb_reg_write),
    .i_memwb_result(i_memwb_result),
    .o_stall(o_stall), .o_valid(o_valid), .o_pc(o_pc),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_sel(o_alu_sel), .o_sign(o_sign),
    .o_store_data(o_store_data), .o_rd_addr(o_rd_addr),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic exp_t bubble(input string tag);
    exp_t e;
    e.tag = tag; e.valid = 1'b0; e.pc = '0; e.a = '0; e.b = '0; e.sd = '0;
    e.sel = '0; e.sign = 1'b0; e.rd = '0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
    return e;
  endfunction

  function automatic exp_t instr_exp(input string tag, input logic [31:0] pc,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] sd, input logic [3:0] sel,
                                     input logic sign, input logic [4:0] rd,
                                     input logic rw, input logic mr, input logic mw);
    exp_t e;
    e.tag = tag; e.valid = 1'b1; e.pc = pc; e.a = a; e.b = b; e.sd = sd;
    e.sel = sel; e.sign = sign; e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw;
    return e;
  endfunction

  // Advance one edge, sample 1ns later and retire every queued expectation.
  task automatic tick_and_check();
    exp_t e;
    @(posedge i_clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".valid"}, {31'b0, o_valid}, {31'b0, e.valid});
      check({e.tag, ".pc"}, o_pc, e.pc);
      check({e.tag, ".alu_a"}, o_alu_a, e.a);
      check({e.tag, ".alu_b"}, o_alu_b, e.b);
      check({e.tag, ".store"}, o_store_data, e.sd);
      check({e.tag, ".sel"}, {28'b0, o_alu_sel}, {28'b0, e.sel});
      check({e.tag, ".sign"}, {31'b0, o_sign}, {31'b0, e.sign});
      check({e.tag, ".rd"}, {27'b0, o_rd_addr}, {27'b0, e.rd});
      check({e.tag, ".ctl"}, {29'b0, o_reg_write, o_mem_read, o_mem_write},
            {29'b0, e.rw, e.mr, e.mw});
    end
  endtask

  task automatic clear_fwd();
    i_exmem_rd = '0; i_exmem_reg_write = 1'b0; i_exmem_result = '0;
    i_memwb_rd = '0; i_memwb_reg_write = 1'b0; i_memwb_result = '0;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [4:0] rd,
                       input logic [3:0] sel, input logic sign,
                       input logic a_pc, input logic b_imm,
                       input logic rw, input logic mr, input logic mw);
    i_valid = v; i_pc = pc;
    i_rs1_addr = rs1; i_rs1_used = (rs1 != 5'd0); i_rs1_data = d1;
    i_rs2_addr = rs2; i_rs2_used = (rs2 != 5'd0); i_rs2_data = d2;
    i_imm = imm; i_rd_addr = rd; i_alu_sel = sel; i_sign = sign;
    i_a_is_pc = a_pc; i_b_is_imm = b_imm;
    i_reg_write = rw; i_mem_read = mr; i_mem_write = mw;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    i_rst = 1'b1;
    i_flush = 1'b0;
    idle();
    clear_fwd();

    // Reset state.
    #2;
    check("rst.valid", {31'b0, o_valid}, 32'd0);
    check("rst.alu_a", o_alu_a, 32'd0);
    check("rst.alu_b", o_alu_b, 32'd0);
    check("rst.stall", {31'b0, o_stall}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Plain ADD x5 = x1 + x2.
    drive(1'b1, 32'h40, 5'd1, 32'd5, 5'd2, 32'd7, '0, 5'd5, ALU_ADD, 1'b0,
          1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back(instr_exp("add", 32'h40, 32'd5, 32'd7, 32'd7, ALU_ADD, 1'b0, 5'd5,
                           1'b1, 1'b0, 1'b0));
    tick_and_check();

    // Forwarding priority on rs1 = x4; rs2 = x6 untouched.
    drive(1'b1, 32'h44, 5'd4, 32'h1111, 5'd6, 32'h22, '0, 5'd8, ALU_SUB, 1'b1,
          1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    i_exmem_rd = 5'd4; i_exmem_reg_write = 1'b1; i_exmem_result = 32'hAAAA;
    i_memwb_rd = 5'd4; i_memwb_reg_write = 1'b1; i_memwb_result = 32'hBBBB;
    sb.push_back(instr_exp("fwd_exmem", 32'h44, 32'hAAAA, 32'h22, 32'h22, ALU_SUB,
                           1'b1, 5'd8, 1'b1, 1'b0, 1'b0));
    tick_and_check();
    i_exmem_reg_write = 1'b0;
    #1;
    check("fwd_memwb.alu_a", o_alu_a, 32'hBBBB);

    // x0 source never forwards even when both writers claim rd = 0.
    drive(1'b1, 32'h48, 5'd0, 32'd0, 5'd0, 32'd0, '0, 5'd9, ALU_OR, 1'b0,
          1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    i_exmem_rd = 5'd0; i_exmem_reg_write = 1'b1; i_exmem_result = 32'hAAAA;
    i_memwb_rd = 5'd0; i_memwb_reg_write = 1'b1; i_memwb_result = 32'hBBBB;
    sb.push_back(instr_exp("fwd_x0", 32'h48, 32'd0, 32'd0, 32'd0, ALU_OR, 1'b0, 5'd9,
                           1'b1, 1'b0, 1'b0));
    tick_and_check();
    clear_fwd();

    // Load-use: LW x3, 4(x1) followed by ADD x7 = x3 + x2.
    drive(1'b1, 32'h50, 5'd1, 32'h100, 5'd0, 32'd0, 32'd4, 5'd3, ALU_ADD, 1'b0,
          1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    sb.push_back(instr_exp("lw", 32'h50, 32'h100, 32'd4, 32'd0, ALU_ADD, 1'b0, 5'd3,
                           1'b1, 1'b1, 1'b0));
    tick_and_check();
    drive(1'b1, 32'h54, 5'd3, 32'd0, 5'd2, 32'd7, '0, 5'd7, ALU_ADD, 1'b0,
          1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    check("lu.stall_on", {31'b0, o_stall}, 32'd1);
    sb.push_back(bubble("lu_bubble"));
    i_exmem_rd = 5'd3; i_exmem_reg_write = 1'b1; i_exmem_result = 32'h1234;
    tick_and_check();
    check("lu.stall_off", {31'b0, o_stall}, 32'd0);
    sb.push_back(instr_exp("lu_add", 32'h54, 32'h1234, 32'd7, 32'd7, ALU_ADD, 1'b0,
                           5'd7, 1'b1, 1'b0, 1'b0));
    tick_and_check();
    clear_fwd();

    // Flush a valid store.
    drive(1'b1, 32'h60, 5'd1, 32'h10, 5'd2, 32'h20, 32'd8, 5'd0, ALU_ADD, 1'b0,
          1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    i_flush = 1'b1;
    sb.push_back(bubble("flush"));
    tick_and_check();
    i_flush = 1'b0;

    // Flush while a load-use stall is raised: still a bubble, ADD not captured.
    drive(1'b1, 32'h70, 5'd1, 32'h200, 5'd0, 32'd0, 32'd0, 5'd3, ALU_ADD, 1'b0,
          1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    sb.push_back(instr_exp("lw2", 32'h70, 32'h200, 32'd0, 32'd0, ALU_ADD, 1'b0, 5'd3,
                           1'b1, 1'b1, 1'b0));
    tick_and_check();
    drive(1'b1, 32'h74, 5'd2, 32'd1, 5'd3, 32'd0, '0, 5'd7, ALU_ADD, 1'b0,
          1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    i_flush = 1'b1;
    #1;
    check("fl_stall.stall", {31'b0, o_stall}, 32'd1);
    sb.push_back(bubble("fl_stall"));
    tick_and_check();
    i_flush = 1'b0;
    idle();
    sb.push_back(bubble("fl_stall_after"));
    tick_and_check();

    // PC / immediate operand select, store data forwarded from MEM/WB.
    drive(1'b1, 32'h100, 5'd1, 32'h33, 5'd9, 32'h55, 32'hFFFF_F800, 5'd10, ALU_ADD,
          1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    i_memwb_rd = 5'd9; i_memwb_reg_write = 1'b1; i_memwb_result = 32'h9999;
    sb.push_back(instr_exp("pc_imm", 32'h100, 32'h100, 32'hFFFF_F800, 32'h9999,
                           ALU_ADD, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0));
    tick_and_check();
    clear_fwd();

    // Asynchronous reset mid-stall clears outputs and drops o_stall at once.
    drive(1'b1, 32'h80, 5'd1, 32'h300, 5'd0, 32'd0, 32'd0, 5'd3, ALU_ADD, 1'b0,
          1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    sb.push_back(instr_exp("lw3", 32'h80, 32'h300, 32'd0, 32'd0, ALU_ADD, 1'b0, 5'd3,
                           1'b1, 1'b1, 1'b0));
    tick_and_check();
    drive(1'b1, 32'h84, 5'd3, 32'd0, 5'd0, 32'd0, '0, 5'd7, ALU_ADD, 1'b0,
          1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    check("rst_mid.stall_before", {31'b0, o_stall}, 32'd1);
    #1;
    i_rst = 1'b1;
    #1;
    check("rst_mid.stall", {31'b0, o_stall}, 32'd0);
    check("rst_mid.valid", {31'b0, o_valid}, 32'd0);
    check("rst_mid.alu_a", o_alu_a, 32'd0);
    check("rst_mid.ctl", {29'b0, o_reg_write, o_mem_read, o_mem_write}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    // With EX empty there is no hazard, so the held ADD enters on the next edge.
    sb.push_back(instr_exp("post_rst", 32'h84, 32'd0, 32'd0, 32'd0, ALU_ADD, 1'b0,
                           5'd7, 1'b1, 1'b0, 1'b0));
    tick_and_check();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
